// File: rtl/div_seq_pkg.sv
// Shared encodings for the iterative radix-2 divide/remainder sequencer.
package div_seq_pkg;

   localparam int DIV_XLEN   = 64;
   localparam int DIV_WORD_W = 32;

   // Bit positions inside div_op
   localparam int DIV_OP_WORD = 2;
   localparam int DIV_OP_SGN  = 1;
   localparam int DIV_OP_REM  = 0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the remainder:quotient pair left and trial-subtract.
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // The remainder is always below the divisor, so one extra bit covers the shifted value
   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs_i};

   always_comb begin
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms, with
// valid/ready issue and result handshakes.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_valid,
   output logic            div_ready,
   input  logic [2:0]      div_op,
   input  logic [XLEN-1:0] div_src1,
   input  logic [XLEN-1:0] div_src2,
   input  logic            flush,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_data,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam int WW = DIV_WORD_W;

   div_state_e      state_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            word_q, sel_rem_q, q_neg_q, r_neg_q;
   logic            res_valid_q;
   logic [XLEN-1:0] res_data_q;

   logic [XLEN-1:0] rem_d, quo_d;
   logic [XLEN-1:0] s1_ext, s2_ext, a1, a2, quo_init, min_val, dividend_ret, special_res;
   logic            op_word, op_sgn, op_rem, neg1, neg2, dvz, ovf;
   logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

   function automatic logic [XLEN-1:0] sext_w(input logic [WW-1:0] v);
      return {{(XLEN-WW){v[WW-1]}}, v};
   endfunction

   assign op_word = div_op[DIV_OP_WORD];
   assign op_sgn  = div_op[DIV_OP_SGN];
   assign op_rem  = div_op[DIV_OP_REM];

   // Operand capture: width select, sign handling and the two early-out cases
   always_comb begin
      s1_ext       = op_word ? {{(XLEN-WW){op_sgn & div_src1[WW-1]}}, div_src1[WW-1:0]} : div_src1;
      s2_ext       = op_word ? {{(XLEN-WW){op_sgn & div_src2[WW-1]}}, div_src2[WW-1:0]} : div_src2;
      neg1         = op_sgn & s1_ext[XLEN-1];
      neg2         = op_sgn & s2_ext[XLEN-1];
      a1           = neg1 ? -s1_ext : s1_ext;
      a2           = neg2 ? -s2_ext : s2_ext;
      quo_init     = op_word ? (a1 << WW) : a1;
      min_val      = op_word ? sext_w({1'b1, {(WW-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
      dividend_ret = op_word ? sext_w(div_src1[WW-1:0]) : div_src1;
      dvz          = (s2_ext == '0);
      ovf          = op_sgn && (s1_ext == min_val) && (s2_ext == '1);
      if (dvz) special_res = op_rem ? dividend_ret : '1;
      else     special_res = op_rem ? '0 : dividend_ret;
   end

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_d),
      .quo_o (quo_d)
   );

   always_comb begin
      q_fix   = q_neg_q ? -quo_d : quo_d;
      r_fix   = r_neg_q ? -rem_d : rem_d;
      sel_fix = sel_rem_q ? r_fix : q_fix;
      fix_res = word_q ? sext_w(sel_fix[WW-1:0]) : sel_fix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DIV_IDLE;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         cnt_q       <= '0;
      end else if (flush) begin
         state_q     <= DIV_IDLE;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (div_valid) begin
                  word_q    <= op_word;
                  sel_rem_q <= op_rem;
                  q_neg_q   <= neg1 ^ neg2;
                  r_neg_q   <= neg1;
                  rem_q     <= '0;
                  quo_q     <= quo_init;
                  dvs_q     <= a2;
                  if (dvz || ovf) begin
                     res_data_q  <= special_res;
                     res_valid_q <= 1'b1;
                     state_q     <= DIV_DONE;
                  end else begin
                     cnt_q   <= op_word ? CW'(WW-1) : CW'(XLEN-1);
                     state_q <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) begin
                  res_data_q  <= fix_res;
                  res_valid_q <= 1'b1;
                  state_q     <= DIV_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DIV_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= DIV_IDLE;
               end
            end
            default: state_q <= DIV_IDLE;
         endcase
      end
   end

   assign div_ready = (state_q == DIV_IDLE) && !rst;
   assign busy      = (state_q != DIV_IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, handshake scenarios and
// randomized ops against an arithmetic reference model.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_valid;
   logic        div_ready;
   logic [2:0]  div_op;
   logic [63:0] div_src1, div_src2;
   logic        flush;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_seq #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .div_op    (div_op),
      .div_src1  (div_src1),
      .div_src2  (div_src2),
      .flush     (flush),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
   );

   // Reference: RISC-V M-extension semantics using plain language-level division
   function automatic void ref_div(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] res, output int lat);
      bit word = op[2], sgn = op[1], rm = op[0];
      logic [63:0] r;
      if (word) begin
         logic [31:0] a32 = a[31:0], b32 = b[31:0];
         logic [31:0] r32;
         lat = 33;
         if (b32 == 32'd0) begin
            r32 = rm ? a32 : 32'hFFFF_FFFF; lat = 1;
         end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            r32 = rm ? 32'd0 : a32; lat = 1;
         end else if (sgn) begin
            int sa = a32, sb = b32;
            r32 = rm ? sa % sb : sa / sb;
         end else begin
            r32 = rm ? a32 % b32 : a32 / b32;
         end
         r = {{32{r32[31]}}, r32};
      end else begin
         lat = 65;
         if (b == 64'd0) begin
            r = rm ? a : '1; lat = 1;
         end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            r = rm ? 64'd0 : a; lat = 1;
         end else if (sgn) begin
            longint sa = a, sb = b;
            r = rm ? sa % sb : sa / sb;
         end else begin
            r = rm ? a % b : a / b;
         end
      end
      res = r;
   endfunction

   // Issues one op and waits for its result; optionally lets the result be consumed.
   task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit consume, output logic [63:0] data, output int lat,
                         output int acc_cyc, output bit to);
      int w = 0;
      to = 1'b0; lat = 0; data = '0; acc_cyc = 0;
      @(negedge clk);
      while (!div_ready && w < 300) begin @(negedge clk); w++; end
      if (!div_ready) begin to = 1'b1; return; end
      div_op = op; div_src1 = a; div_src2 = b; div_valid = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      acc_cyc = cyc;
      lat = 1;
      while (!res_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      if (!res_valid) begin to = 1'b1; return; end
      data = res_data;
      if (consume) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1; div_valid = 1'b0; div_op = '0; div_src1 = '0; div_src2 = '0;
      flush = 1'b0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (div_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", div_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
      n_cmp++; if (res_data !== 64'd0) begin n_fail++; $display("FAIL rst_res_data: got %h want 0", res_data); end
      rst = 1'b0;
      #1;
      n_cmp++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", div_ready); end
   endtask

   typedef struct { logic [2:0] op; logic [63:0] a, b, exp; int lat; } vec_t;

   task automatic test_directed();
      vec_t v[8];
      logic [63:0] d; int lat, acc; bit to;
      v[0] = '{3'b000, 64'd100, 64'd7, 64'd14, 65};
      v[1] = '{3'b001, 64'd100, 64'd7, 64'd2, 65};
      v[2] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
      v[3] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      v[4] = '{3'b000, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      v[5] = '{3'b001, 64'd5, 64'd0, 64'd5, 1};
      v[6] = '{3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      v[7] = '{3'b011, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      for (int i = 0; i < 8; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 1'b1, d, lat, acc, to);
         n_cmp++;
         if (to) begin n_fail++; $display("FAIL dir%0d_timeout: no result", i); continue; end
         if (d !== v[i].exp) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, d, v[i].exp); end
         n_cmp++;
         if (lat != v[i].lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      div_op = 3'b000; div_src1 = 64'd1000; div_src2 = 64'd3; div_valid = 1'b1;
      @(posedge clk); #1; div_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_cmp++; if (res_data !== 64'd0) begin n_fail++; $display("FAIL rstmid_res_data: got %h want 0", res_data); end
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_res_valid: got %b want 0", res_valid); end
   endtask

   task automatic test_stall();
      logic [63:0] d; int lat, acc; bit to; bit bad = 0;
      res_ready = 1'b0;
      run_op(3'b000, 64'd12345, 64'd10, 1'b0, d, lat, acc, to);
      n_cmp++;
      if (to || d !== 64'd1234) begin n_fail++; $display("FAIL stall_data: got %h want %h (timeout %b)", d, 64'd1234, to); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (res_data !== d || div_ready !== 1'b0 || res_valid !== 1'b1) bad = 1;
      end
      n_cmp++;
      if (bad) begin n_fail++; $display("FAIL stall_hold: got data %h ready %b valid %b want data %h ready 0 valid 1", res_data, div_ready, res_valid, d); end
      res_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || div_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: got busy %b valid %b ready %b want 0 0 1", busy, res_valid, div_ready);
      end
   endtask

   task automatic test_flush();
      logic [63:0] d; int lat, acc; bit to; bit seen = 0;
      @(negedge clk);
      div_op = 3'b000; div_src1 = 64'hFFFF_0000_1234_5678; div_src2 = 64'd77; div_valid = 1'b1;
      @(posedge clk); #1; div_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || div_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got busy %b ready %b want 0 1", busy, div_ready); end
      for (int i = 0; i < 70; i++) begin
         if (res_valid) seen = 1;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (seen) begin n_fail++; $display("FAIL flush_no_result: got res_valid pulse want none"); end
      // flush alongside div_valid in IDLE must not accept
      @(negedge clk);
      div_op = 3'b000; div_src1 = 64'd50; div_src2 = 64'd5; div_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1; div_valid = 1'b0; flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_noaccept: got busy %b want 0", busy); end
      run_op(3'b000, 64'd9, 64'd3, 1'b1, d, lat, acc, to);
      n_cmp++;
      if (to || d !== 64'd3) begin n_fail++; $display("FAIL flush_next: got %h want 3 (timeout %b)", d, to); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d1, d2, e1, e2; int lat, acc1, acc2, el; bit to1, to2;
      ref_div(3'b000, 64'd1_000_000_007, 64'd13, e1, el);
      ref_div(3'b100, 64'h0000_0000_FFFF_FFF0, 64'd3, e2, el);
      run_op(3'b000, 64'd1_000_000_007, 64'd13, 1'b1, d1, lat, acc1, to1);
      n_cmp++;
      if (div_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got ready %b busy %b want 1 0", div_ready, busy); end
      run_op(3'b100, 64'h0000_0000_FFFF_FFF0, 64'd3, 1'b1, d2, lat, acc2, to2);
      n_cmp++;
      if (to1 || d1 !== e1) begin n_fail++; $display("FAIL b2b_first: got %h want %h", d1, e1); end
      n_cmp++;
      if (to2 || d2 !== e2) begin n_fail++; $display("FAIL b2b_second: got %h want %h", d2, e2); end
      n_cmp++;
      if (acc2 - acc1 != 66) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 66", acc2 - acc1); end
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return '1;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'hFFFF_FFFF_8000_0000;
         4: return 64'($urandom_range(1, 100));
         5: return {32'($urandom), 32'($urandom_range(0, 1000))};
         6: return 64'h0000_0000_8000_0000;
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   task automatic test_random();
      logic [63:0] a, b, d, e; logic [2:0] op; int lat, elat, acc; bit to;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         ref_div(op, a, b, e, elat);
         run_op(op, a, b, 1'b1, d, lat, acc, to);
         n_cmp++;
         if (to || d !== e) begin
            n_fail++; $display("FAIL rand%0d_data: op %b a %h b %h got %h want %h", i, op, a, b, d, e);
         end
         n_cmp++;
         if (lat != elat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, elat); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_stall();
      test_flush();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative radix-2 divide/remainder sequencer for the RV64 execute stage. It replaces the single-cycle `/` and `%` paths (DIVU, REMU, DIVW, REMW and their signed/unsigned counterparts) with a multi-cycle restoring divider. Issue and result use valid/ready handshakes. The decoder routes divide-class ALU ops here and stalls the pipeline while `div_ready` is low or no result is pending.

## Interface
Parameters:
- `XLEN`, 64: operand and result width.

Ports:
- `clk` input 1: single clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `div_valid` input 1: an operation is presented.
- `div_ready` output 1: the block accepts an operation this cycle.
- `div_op` input 3: bit 2 `word` (32-bit op), bit 1 `sgn` (signed), bit 0 `rem` (return remainder rather than quotient).
- `div_src1` input XLEN: dividend.
- `div_src2` input XLEN: divisor.
- `flush` input 1: abort any in-flight operation.
- `res_valid` output 1: the result is available.
- `res_ready` input 1: the consumer takes the result.
- `res_data` output XLEN: quotient or remainder.
- `busy` output 1: the state is not IDLE.

## Operation
States are IDLE, CALC and DONE.

- **IDLE**
  - `div_ready` = 1 (0 while `rst` is high).
  - An operation is accepted on `div_valid && div_ready && !flush`.
  - At accept, the block latches the op and forms the working operands:
    - Word ops take `src[31:0]`, sign- or zero-extended.
    - Signed ops take absolute values and record `q_neg = s1^s2` and `r_neg = s1` (the dividend's sign).
  - Divisor == 0: go straight to DONE. The result is quotient = all ones and remainder = original dividend (for word ops, the low 32 bits sign-extended).
  - Signed overflow (dividend = most-negative value, divisor = -1, signed op): go straight to DONE. The result is quotient = dividend and remainder = 0.
  - Otherwise go to CALC and load the counter with N-1, where N = 32 for word ops and 64 otherwise.
- **CALC**
  - Each cycle performs one restoring step: shift the remainder:quotient pair left by 1, trial-subtract the divisor, and set the quotient LSB if the subtraction is non-negative.
  - The counter decrements. On count == 0, the block applies sign fixup (negate the quotient if `q_neg`, negate the remainder if `r_neg`), selects by `rem`, and registers `res_data`.
  - Word results: `res_data` = sign-extension of bit 31 of the 32-bit result, for both signed and unsigned word ops.
  - Then go to DONE.
- **DONE**
  - `res_valid` = 1, and `res_data` is held stable until `res_ready`.
  - On `res_ready`, go to IDLE.
  - No new operation is accepted in DONE.
- **flush**
  - From any state, the next state is IDLE and `res_valid` = 0; the in-flight result is discarded.
  - `flush` together with `div_valid` in IDLE means no accept.
- **Reset**: state IDLE, `res_valid` 0, `res_data` 0, counter 0, `busy` 0. Reset mid-CALC discards the operation.

## Timing
- The accept edge ends cycle 0.
- Normal op: CALC occupies cycles 1..N, and `res_valid` rises in cycle N+1. That is 65 cycles of latency for 64-bit ops and 33 for word ops.
- Divide-by-zero and overflow: `res_valid` in cycle 1.
- With `res_ready` held high, DONE lasts 1 cycle. The next accept is possible in cycle N+2, so sustained throughput is one op per N+2 cycles.
- `div_ready` and `busy` decode directly from the state register and have no combinational path from inputs, except that `div_ready` is gated by `rst`.
- `res_valid` and `res_data` are registered outputs.

## Structure
- Add `DIV_OP_WORD`, `DIV_OP_SGN`, `DIV_OP_REM` (bit indices), the state encodings `DIV_IDLE`/`DIV_CALC`/`DIV_DONE`, and `XLEN` to `rvseed_defines.v`.
- One combinational sub-module, `div_step`:
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder and next quotient.
  - It is instantiated once and reused every cycle.
- The FSM, counter, operand capture and sign fixup live in `div_seq`.

## Test plan
- DIVU 100/7 → `res_data` 14, `res_valid` in cycle 65. REMU 100/7 → 2.
- DIVW, signed -7/2 (src1 = 0xFFFFFFFFFFFFFFF9) → 0xFFFFFFFFFFFFFFFD after 33 cycles. REMW on the same operands → 0xFFFFFFFFFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFFFFFFFFFF in cycle 1. REMU 5/0 → 5.
- Signed DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → 0x8000000000000000 in cycle 1. REM on the same operands → 0.
- `res_ready` held low for 5 cycles after `res_valid` → `res_data` stable and `div_ready` 0 throughout. The result is taken on the first `res_ready` cycle, and IDLE follows next cycle.
- `flush` in cycle 10 of a 64-bit op → IDLE next cycle with no `res_valid` pulse. An immediately following DIVU 9/3 returns 3 correctly.
